// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN transmit bit-stuffing path.
package can_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int unsigned STUFF_LIMIT = 5;
    localparam logic        RECESSIVE   = 1'b1;

    // Equal-bit run after emitting a bit; a run of 0 means no history, so any bit starts at 1.
    function automatic logic [2:0] run_next(input logic [2:0] run, input logic same);
        logic [2:0] result;
        if (same && (run != 3'd0)) begin
            if (run >= 3'(STUFF_LIMIT)) begin
                result = 3'(STUFF_LIMIT);
            end else begin
                result = run + 3'd1;
            end
        end else begin
            result = 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/can_stuff_counter.sv
// Tracks the last emitted bit and the equal-bit run length; requests a stuff bit at the limit.
module can_stuff_counter
    import can_tx_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic emit,
    input  logic emit_bit,
    output logic last,
    output logic stuff_req
);

    logic       last_r;
    logic [2:0] run_r;

    // Run history: clear drops the run but last still follows any bit emitted on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_r <= RECESSIVE;
            run_r  <= 3'd0;
        end else begin
            if (clear) begin
                run_r <= 3'd0;
            end else if (emit) begin
                run_r <= run_next(run_r, emit_bit == last_r);
            end else begin
                run_r <= run_r;
            end
            if (emit) begin
                last_r <= emit_bit;
            end else begin
                last_r <= last_r;
            end
        end
    end

    assign last      = last_r;
    assign stuff_req = (run_r == 3'(STUFF_LIMIT));

endmodule

// File: rtl/can_tx_bitstuffer.sv
// CAN transmit serializer: shifts loaded segments out MSB-first per strobe with bit stuffing.
module can_tx_bitstuffer
    import can_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LENW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LENW-1:0]  len,
    input  logic             stuff_en,
    input  logic             tx_strobe,
    input  logic             abort,
    output logic             bitout,
    output logic             stuffbit,
    output logic             busy,
    output logic             done
);

    tx_state_e        state_r, state_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [LENW-1:0]  bits_left_r, bits_left_s;
    logic             bitout_r, bitout_s;
    logic             stuffbit_r, stuffbit_s;
    logic             busy_r;
    logic             done_r, done_s;
    logic [LENW-1:0]  len_eff_s;
    logic             emit_s, emit_bit_s;
    logic             last_s, stuff_req_s;

    assign len_eff_s = (len > LENW'(WIDTH)) ? LENW'(WIDTH) : len;

    can_stuff_counter u_stuff_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (abort | frame_start),
        .emit      (emit_s),
        .emit_bit  (emit_bit_s),
        .last      (last_s),
        .stuff_req (stuff_req_s)
    );

    // Next-state and output computation; abort overrides whatever the FSM chose.
    always_comb begin
        state_s     = state_r;
        sreg_s      = sreg_r;
        bits_left_s = bits_left_r;
        bitout_s    = bitout_r;
        stuffbit_s  = stuffbit_r;
        done_s      = 1'b0;
        emit_s      = 1'b0;
        emit_bit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load && (len_eff_s != {LENW{1'b0}})) begin
                    sreg_s      = data << (LENW'(WIDTH) - len_eff_s);
                    bits_left_s = len_eff_s;
                    state_s     = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (tx_strobe) begin
                    emit_s = 1'b1;
                    if (stuff_en && stuff_req_s) begin
                        bitout_s   = ~last_s;
                        stuffbit_s = 1'b1;
                        emit_bit_s = ~last_s;
                    end else begin
                        bitout_s    = sreg_r[WIDTH-1];
                        stuffbit_s  = 1'b0;
                        emit_bit_s  = sreg_r[WIDTH-1];
                        sreg_s      = {sreg_r[WIDTH-2:0], 1'b0};
                        bits_left_s = bits_left_r - LENW'(1);
                        if (bits_left_r == LENW'(1)) begin
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end else begin
                            state_s = SHIFT;
                        end
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (abort) begin
            state_s     = IDLE;
            bitout_s    = RECESSIVE;
            stuffbit_s  = 1'b0;
            bits_left_s = {LENW{1'b0}};
            done_s      = 1'b0;
            emit_s      = 1'b0;
        end else begin
            emit_s = emit_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            sreg_r      <= {WIDTH{1'b0}};
            bits_left_r <= {LENW{1'b0}};
            bitout_r    <= RECESSIVE;
            stuffbit_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            sreg_r      <= sreg_s;
            bits_left_r <= bits_left_s;
            bitout_r    <= bitout_s;
            stuffbit_r  <= stuffbit_s;
            busy_r      <= (state_s == SHIFT);
            done_r      <= done_s;
        end
    end

    assign bitout   = bitout_r;
    assign stuffbit = stuffbit_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_can_tx_bitstuffer.sv
// Self-checking bench for can_tx_bitstuffer: directed scenarios plus random frames vs a bit-queue model.
module tb_can_tx_bitstuffer;

    localparam int WIDTH = 16;
    localparam int LENW  = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             frame_start = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [LENW-1:0]  len = '0;
    logic             stuff_en = 1'b0;
    logic             tx_strobe = 1'b0;
    logic             abort = 1'b0;
    logic             bitout, stuffbit, busy, done;

    int total = 0;
    int bad   = 0;

    // Reference model: pending data bits as a queue, plus bus history as plain integers.
    bit m_q[$];
    bit m_last   = 1'b1;
    int m_run    = 0;
    bit m_busy   = 1'b0;
    bit m_bitout = 1'b1;
    bit m_stuff  = 1'b0;
    bit m_done   = 1'b0;

    can_tx_bitstuffer #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .load        (load),
        .data        (data),
        .len         (len),
        .stuff_en    (stuff_en),
        .tx_strobe   (tx_strobe),
        .abort       (abort),
        .bitout      (bitout),
        .stuffbit    (stuffbit),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_load(input logic [WIDTH-1:0] d, input int l);
        int n;
        m_done = 1'b0;
        n = (l > WIDTH) ? WIDTH : l;
        if (!m_busy && n != 0) begin
            for (int i = n - 1; i >= 0; i--) m_q.push_back(d[i]);
            m_busy = 1'b1;
        end
    endtask

    task automatic model_strobe();
        bit b;
        m_done = 1'b0;
        if (m_busy) begin
            if (stuff_en && m_run == 5) begin
                b = !m_last;
                m_stuff = 1'b1;
                m_run = 1;
            end else begin
                b = m_q.pop_front();
                m_stuff = 1'b0;
                m_run = (b == m_last && m_run != 0) ? ((m_run + 1 > 5) ? 5 : m_run + 1) : 1;
                if (m_q.size() == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            m_last = b;
            m_bitout = b;
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d, input int l);
        load = 1'b1; data = d; len = LENW'(l);
        model_load(d, l);
        step();
        load = 1'b0;
    endtask

    // One idle cycle, then a one-cycle strobe; outputs are valid on return.
    task automatic do_strobe();
        step();
        tx_strobe = 1'b1;
        model_strobe();
        step();
        tx_strobe = 1'b0;
        m_done = m_done;
    endtask

    task automatic do_frame_start();
        frame_start = 1'b1;
        m_run = 0;
        m_done = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++;
        if ({bitout, stuffbit, done, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_state: got %b want 1000", {bitout, stuffbit, done, busy});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_stuff_insertion();
        logic [8:0] exp_bits;
        exp_bits = 9'b000001000;
        stuff_en = 1'b1;
        do_frame_start();
        do_load(16'h0000, 8);
        for (int i = 0; i < 9; i++) begin
            do_strobe();
            total++;
            if ({bitout, stuffbit, done, busy} !== {exp_bits[8-i], i == 5, i == 8, i != 8}) begin
                bad++;
                $display("FAIL stuff_insert[%0d]: got %b want %b", i, {bitout, stuffbit, done, busy},
                         {exp_bits[8-i], i == 5, i == 8, i != 8});
            end
        end
    endtask

    task automatic test_alternating();
        stuff_en = 1'b1;
        do_frame_start();
        do_load(16'hAAAA, 16);
        for (int i = 0; i < 16; i++) begin
            do_strobe();
            total++;
            if ({bitout, stuffbit, done} !== {i % 2 == 0, 1'b0, i == 15}) begin
                bad++;
                $display("FAIL alternating[%0d]: got %b want %b", i, {bitout, stuffbit, done},
                         {i % 2 == 0, 1'b0, i == 15});
            end
        end
    endtask

    task automatic test_cross_segment();
        logic [6:0] exp_bits;
        exp_bits = 7'b1111101;
        stuff_en = 1'b1;
        do_frame_start();
        do_load(16'h000F, 4);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) do_load(16'h0003, 2);
            do_strobe();
            total++;
            if ({bitout, stuffbit, done} !== {exp_bits[6-i], i == 5, i == 3 || i == 6}) begin
                bad++;
                $display("FAIL cross_segment[%0d]: got %b want %b", i, {bitout, stuffbit, done},
                         {exp_bits[6-i], i == 5, i == 3 || i == 6});
            end
        end
    endtask

    task automatic test_stuff_disabled();
        stuff_en = 1'b0;
        do_frame_start();
        do_load(16'h0000, 6);
        for (int i = 0; i < 6; i++) begin
            do_strobe();
            total++;
            if ({bitout, stuffbit, done} !== {1'b0, 1'b0, i == 5}) begin
                bad++;
                $display("FAIL stuff_disabled[%0d]: got %b want %b", i, {bitout, stuffbit, done},
                         {1'b0, 1'b0, i == 5});
            end
        end
        stuff_en = 1'b1;
    endtask

    task automatic test_abort();
        stuff_en = 1'b1;
        do_frame_start();
        do_load(16'h5A3C, 16);
        for (int i = 0; i < 3; i++) do_strobe();
        abort = 1'b1;
        m_busy = 1'b0; m_q.delete(); m_bitout = 1'b1; m_stuff = 1'b0; m_run = 0; m_done = 1'b0;
        step();
        abort = 1'b0;
        total++;
        if ({bitout, stuffbit, done, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL abort_state: got %b want 1000", {bitout, stuffbit, done, busy});
        end
        do_load(16'h0002, 2);
        for (int i = 0; i < 2; i++) begin
            do_strobe();
            total++;
            if ({bitout, stuffbit, done, busy} !== {i == 0, 1'b0, i == 1, i == 0}) begin
                bad++;
                $display("FAIL abort_reload[%0d]: got %b want %b", i, {bitout, stuffbit, done, busy},
                         {i == 0, 1'b0, i == 1, i == 0});
            end
        end
    endtask

    task automatic test_edge_cases();
        bit prev_bit;
        // reset mid-segment
        do_load(16'h1234, 16);
        do_strobe();
        do_strobe();
        reset = 1'b0;
        m_busy = 1'b0; m_q.delete(); m_bitout = 1'b1; m_stuff = 1'b0; m_run = 0; m_last = 1'b1; m_done = 1'b0;
        step();
        total++;
        if ({bitout, stuffbit, done, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_mid: got %b want 1000", {bitout, stuffbit, done, busy});
        end
        reset = 1'b1;
        step();
        // zero-length load
        do_load(16'hFFFF, 0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL len_zero: busy got %b want 0", busy);
        end
        // load and strobe together while idle: no bit on that edge
        do_load(16'h0001, 3);
        do_strobe();
        do_strobe();
        do_strobe();
        prev_bit = m_bitout;
        tx_strobe = 1'b1;
        do_load(16'h0000, 3);
        tx_strobe = 1'b0;
        total++;
        if ({bitout, busy} !== {prev_bit, 1'b1}) begin
            bad++;
            $display("FAIL load_with_strobe: got %b want %b", {bitout, busy}, {prev_bit, 1'b1});
        end
        for (int s = 0; s < 8 && m_busy; s++) do_strobe();
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: done got %b want 0", done);
        end
        // oversize length clamps to WIDTH
        do_load(16'hC3A5, 31);
        for (int s = 0; s < 40 && m_busy; s++) begin
            do_strobe();
            total++;
            if ({bitout, stuffbit, done, busy} !== {m_bitout, m_stuff, m_done, m_busy}) begin
                bad++;
                $display("FAIL len_clamp[%0d]: got %b want %b", s, {bitout, stuffbit, done, busy},
                         {m_bitout, m_stuff, m_done, m_busy});
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 30; f++) begin
            stuff_en = ($urandom_range(0, 3) != 0);
            do_frame_start();
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                do_load(WIDTH'($urandom), int'($urandom_range(1, WIDTH)));
                for (int s = 0; s < 40 && m_busy; s++) begin
                    if ($urandom_range(0, 15) == 0) stuff_en = ~stuff_en;
                    do_strobe();
                    total++;
                    if ({bitout, stuffbit, done, busy} !== {m_bitout, m_stuff, m_done, m_busy}) begin
                        bad++;
                        $display("FAIL random f%0d g%0d s%0d: got %b want %b", f, g, s,
                                 {bitout, stuffbit, done, busy}, {m_bitout, m_stuff, m_done, m_busy});
                    end
                end
                total++;
                if (m_busy || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL random_timeout f%0d: busy got %b want 0", f, busy);
                    m_busy = 1'b0;
                    m_q.delete();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stuff_insertion();
        test_alternating();
        test_cross_segment();
        test_stuff_disabled();
        test_abort();
        test_edge_cases();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
